// File: rtl/instr_encoder_writer.sv
// Encodes decoded RV32I instruction descriptors into 32-bit words and streams
// them into instruction memory through a registered write port.
module instr_encoder_writer #(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        opcode,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [31:0]       imm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [31:0]       imem_wdata,
  output logic              err,
  output logic              full,
  output logic [ADDR_W:0]   count
);

  typedef enum logic [2:0] {
    FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_BAD
  } fmt_e;

  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W:0]   LAST_CNT = {1'b0, {ADDR_W{1'b1}}};

  fmt_e        fmt;
  logic        legal;
  logic [31:0] word_next;
  logic [6:0]  op7;
  logic        accept;

  logic              we_reg;
  logic [ADDR_W-1:0] waddr_reg;
  logic [31:0]       wdata_reg;
  logic              err_reg;
  logic              full_reg;
  logic [ADDR_W:0]   count_reg;

  assign op7      = {opcode, 2'b11};
  assign in_ready = !full_reg && !clear;
  assign accept   = in_valid && in_ready;

  always_comb begin
    fmt = FMT_BAD;
    case (opcode)
      5'b01100:                   fmt = FMT_R;
      5'b00100, 5'b00000, 5'b11001: fmt = FMT_I;
      5'b01000:                   fmt = FMT_S;
      5'b11000:                   fmt = FMT_B;
      5'b01101, 5'b00101:         fmt = FMT_U;
      5'b11011:                   fmt = FMT_J;
      default:                    fmt = FMT_BAD;
    endcase
  end

  // Range checks reduce to "upper bits are a pure sign extension" of the field.
  always_comb begin
    legal     = 1'b0;
    word_next = 32'd0;
    case (fmt)
      FMT_R: begin
        legal     = 1'b1;
        word_next = {funct7, rs2, rs1, funct3, rd, op7};
      end
      FMT_I: begin
        legal     = (imm[31:11] == {21{imm[11]}});
        word_next = {imm[11:0], rs1, funct3, rd, op7};
      end
      FMT_S: begin
        legal     = (imm[31:11] == {21{imm[11]}});
        word_next = {imm[11:5], rs2, rs1, funct3, imm[4:0], op7};
      end
      FMT_B: begin
        legal     = (imm[31:12] == {20{imm[12]}}) && !imm[0];
        word_next = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], op7};
      end
      FMT_U: begin
        legal     = (imm[11:0] == 12'd0);
        word_next = {imm[31:12], rd, op7};
      end
      FMT_J: begin
        legal     = (imm[31:20] == {12{imm[20]}}) && !imm[0];
        word_next = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op7};
      end
      default: begin
        legal     = 1'b0;
        word_next = 32'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_reg    <= 1'b0;
      waddr_reg <= BASE;
      wdata_reg <= 32'd0;
      err_reg   <= 1'b0;
      full_reg  <= 1'b0;
      count_reg <= '0;
    end else begin
      we_reg  <= 1'b0;
      err_reg <= 1'b0;
      if (accept) begin
        if (legal) begin
          we_reg    <= 1'b1;
          waddr_reg <= BASE + count_reg[ADDR_W-1:0];
          wdata_reg <= word_next;
          count_reg <= count_reg + 1'b1;
          full_reg  <= (count_reg == LAST_CNT);
        end else begin
          err_reg <= 1'b1;
        end
      end
      // accept is impossible while clear is high, so this never drops a write
      if (clear) begin
        count_reg <= '0;
        full_reg  <= 1'b0;
      end
    end
  end

  assign imem_we    = we_reg;
  assign imem_waddr = waddr_reg;
  assign imem_wdata = wdata_reg;
  assign err        = err_reg;
  assign full       = full_reg;
  assign count      = count_reg;

endmodule
